// File: rtl/ipsxb_fft_rst_seq.sv
// Reset synchroniser and sequencer for the FFT core: synchronises the async reset release,
// stretches it, then releases NUM_CH downstream reset domains one after another.
`timescale 1ns/1ps
module ipsxb_fft_rst_seq #(
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_GAP         = 8
) (
    input  logic              i_clk,
    input  logic              i_arstn_presync,
    input  logic              i_sw_rst,
    output logic              o_arstn_synced,
    output logic [NUM_CH-1:0] o_rstn_ch,
    output logic              o_all_released,
    output logic              o_busy
);

    localparam int unsigned MAX_CNT = (STRETCH_CYCLES > CH_GAP) ? STRETCH_CYCLES : CH_GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    generate
        if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || NUM_CH < 1 || CH_GAP < 1) begin : g_param_err
            $error("ipsxb_fft_rst_seq: parameter below its legal minimum");
        end
    endgenerate

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StDone
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_CH-1:0]      r_rstn_ch;
    logic [NUM_CH-1:0]      w_rstn_ch_nxt;
    logic                   r_all_released;
    logic                   w_all_nxt;
    logic                   r_busy;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Only the release edge is synchronised; assertion goes straight through the async clear.
    always_ff @(posedge i_clk or negedge i_arstn_presync) begin
        if (!i_arstn_presync) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn_presync) begin
        if (!i_arstn_presync) begin
            r_state        <= StHold;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_rstn_ch      <= '0;
            r_all_released <= 1'b0;
            r_busy         <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_rstn_ch      <= w_rstn_ch_nxt;
            r_all_released <= w_all_nxt;
            r_busy         <= ~w_all_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_rstn_ch_nxt = r_rstn_ch;
        w_all_nxt     = r_all_released;

        if (i_sw_rst) begin
            // Restart the sequence; the synchroniser chain keeps its value.
            w_state_nxt   = StHold;
            w_cnt_nxt     = '0;
            w_idx_nxt     = '0;
            w_rstn_ch_nxt = '0;
            w_all_nxt     = 1'b0;
        end else begin
            case (r_state)
                StHold: begin
                    if (w_synced) begin
                        if (r_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
                            w_rstn_ch_nxt[0] = 1'b1;
                            w_cnt_nxt        = '0;
                            if (NUM_CH == 1) begin
                                w_state_nxt = StDone;
                                w_all_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = StRelease;
                                w_idx_nxt   = IDX_W'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                StRelease: begin
                    if (r_cnt == CNT_W'(CH_GAP - 1)) begin
                        w_rstn_ch_nxt[r_idx] = 1'b1;
                        w_cnt_nxt            = '0;
                        if (r_idx == IDX_W'(NUM_CH - 1)) begin
                            w_state_nxt = StDone;
                            w_all_nxt   = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                    w_state_nxt = StHold;
                end
            endcase
        end
    end

    assign o_arstn_synced = w_synced;
    assign o_rstn_ch      = r_rstn_ch;
    assign o_all_released = r_all_released;
    assign o_busy         = r_busy;

endmodule
